axis_decim_requant: RTL

- Downstream neighbour of the AXI-Stream FIR filter; consumes its full-precision internal-width output stream.
- Keeps one sample in every R (runtime ratio), round-half-up requantizes it to the output Q format with saturation, and re-emits it as AXI-Stream.
- Two-stage pipeline with full backpressure support; feeds DAC/DMA stages.

---
 rtl/axis_decim_requant.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/axis_decim_requant.sv
// axis_decim_requant
// Decimates an AXI-Stream of wide fixed-point samples by a runtime ratio R
// (one kept sample per R, plus every end-of-frame sample), rounds half-up to
// the narrower output Q format with saturation, and re-emits the result.
// Two register stages; both stall together when the output is blocked.

module axis_decim_requant #(
    parameter int in_width          = 32,
    parameter int in_decimal_width  = 30,
    parameter int out_width         = 16,
    parameter int out_decimal_width = 15,
    parameter int ratio_width       = 8
) (
    input  logic                   aclk,
    input  logic                   reset,
    input  logic [in_width-1:0]    s_axis_tdata,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [out_width-1:0]   m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    input  logic [ratio_width-1:0] decim_ratio,
    output logic                   sat_pulse
);

    // Number of fractional bits discarded by the requantization.
    localparam int sh_c = in_decimal_width - out_decimal_width;
    // The rounded sum carries one guard bit so the rounding add never wraps.
    localparam int sw_c = in_width + 1;

    localparam logic [ratio_width-1:0] ratio_zero_c = {ratio_width{1'b0}};
    localparam logic [ratio_width-1:0] ratio_one_c  = {{(ratio_width-1){1'b0}}, 1'b1};

    // Half an output LSB, expressed in input LSBs.
    localparam logic signed [sw_c-1:0] round_c =
        {{(sw_c-sh_c){1'b0}}, 1'b1, {(sh_c-1){1'b0}}};

    // Saturation thresholds on the rounded sum: the shifted value exceeds the
    // output range exactly when the unshifted sum crosses +/-2^(out_width-1+sh).
    localparam logic signed [sw_c-1:0] hi_lim_c =
        {{(sw_c-out_width-sh_c){1'b0}}, 1'b1, {(out_width-1+sh_c){1'b0}}};
    localparam logic signed [sw_c-1:0] lo_lim_c =
        {{(sw_c-out_width-sh_c+1){1'b1}}, {(out_width-1+sh_c){1'b0}}};

    localparam logic [out_width-1:0] out_max_c = {1'b0, {(out_width-1){1'b1}}};
    localparam logic [out_width-1:0] out_min_c = {1'b1, {(out_width-1){1'b0}}};

    logic [ratio_width-1:0]  phase_r;
    logic [ratio_width-1:0]  ratio_q_r;
    logic                    st1_valid_r;
    logic                    st1_last_r;
    logic signed [sw_c-1:0]  st1_sum_r;
    logic                    st2_valid_r;

    logic                    advance_s;
    logic                    accept_s;
    logic                    keep_s;
    logic                    wrap_s;
    logic [ratio_width-1:0]  ratio_eff_s;
    logic [ratio_width-1:0]  ratio_next_s;
    logic                    clip_s;
    logic [out_width-1:0]    quant_s;

    // The pipe moves whenever stage 2 is empty or being drained.
    assign advance_s     = !st2_valid_r || m_axis_tready;
    assign s_axis_tready = advance_s;
    assign accept_s      = s_axis_tvalid && advance_s;
    assign m_axis_tvalid = st2_valid_r;

    // Decimation decisions: keep/drop, period wrap, and the ratio for the next period.
    always_comb begin
        ratio_eff_s  = ratio_q_r;
        ratio_next_s = decim_ratio;
        if (ratio_q_r == ratio_zero_c) begin
            ratio_eff_s = ratio_one_c;
        end else begin
            ratio_eff_s = ratio_q_r;
        end
        if (decim_ratio == ratio_zero_c) begin
            ratio_next_s = ratio_one_c;
        end else begin
            ratio_next_s = decim_ratio;
        end
        keep_s = (phase_r == ratio_zero_c) || s_axis_tlast;
        wrap_s = s_axis_tlast || (phase_r == (ratio_eff_s - ratio_one_c));
    end

    // Saturating requantization of the rounded stage-1 sum.
    always_comb begin
        quant_s = st1_sum_r[sh_c+out_width-1:sh_c];
        clip_s  = 1'b0;
        if (st1_sum_r >= hi_lim_c) begin
            quant_s = out_max_c;
            clip_s  = 1'b1;
        end else if (st1_sum_r < lo_lim_c) begin
            quant_s = out_min_c;
            clip_s  = 1'b1;
        end else begin
            quant_s = st1_sum_r[sh_c+out_width-1:sh_c];
            clip_s  = 1'b0;
        end
    end

    // Phase counter and latched ratio; the ratio only changes at a period or frame boundary.
    always_ff @(posedge aclk) begin
        if (reset) begin
            phase_r   <= ratio_zero_c;
            ratio_q_r <= decim_ratio;
        end else if (accept_s) begin
            if (wrap_s) begin
                phase_r   <= ratio_zero_c;
                ratio_q_r <= ratio_next_s;
            end else begin
                phase_r <= phase_r + ratio_one_c;
            end
        end
    end

    // Stage 1: register kept samples with the half-LSB rounding offset added.
    always_ff @(posedge aclk) begin
        if (reset) begin
            st1_valid_r <= 1'b0;
            st1_last_r  <= 1'b0;
            st1_sum_r   <= {sw_c{1'b0}};
        end else if (advance_s) begin
            st1_valid_r <= accept_s && keep_s;
            if (accept_s && keep_s) begin
                st1_sum_r  <= $signed({s_axis_tdata[in_width-1], s_axis_tdata}) + round_c;
                st1_last_r <= s_axis_tlast;
            end
        end
    end

    // Stage 2: output registers; held while the consumer stalls.
    always_ff @(posedge aclk) begin
        if (reset) begin
            st2_valid_r  <= 1'b0;
            m_axis_tdata <= {out_width{1'b0}};
            m_axis_tlast <= 1'b0;
            sat_pulse    <= 1'b0;
        end else if (advance_s) begin
            st2_valid_r <= st1_valid_r;
            sat_pulse   <= st1_valid_r && clip_s;
            if (st1_valid_r) begin
                m_axis_tdata <= quant_s;
                m_axis_tlast <= st1_last_r;
            end
        end else begin
            sat_pulse <= 1'b0;
        end
    end

endmodule
